spongent_sbox_stage: RTL and testbench



---
 rtl/spongent_sbox_stage_pkg.sv | 13 +
 rtl/spongent_sbox4.sv | 11 +
 rtl/spongent_sbox_stage.sv | 112 +++++++++++
 tb/tb_spongent_sbox_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spongent_sbox_stage_pkg.sv
// Spongent-88 constants shared by the sBoxLayer stage and its S-box.
package spongent_sbox_stage_pkg;

    localparam int             NSBOX_DEF   = 11;
    localparam int             ROUNDS_DEF  = 45;
    localparam int             LC_W_DEF    = 6;
    localparam logic [5:0]     LC_INIT_DEF = 6'h05;

    // Spongent 4-bit S-box, entry i lives in nibble i (LSB nibble = S[0]).
    // S = E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6
    localparam logic [63:0]    SBOX_TBL    = 64'h63C9_58A7_F412_0BDE;

endpackage

// File: rtl/spongent_sbox4.sv
// Combinational 4-bit Spongent S-box lookup.
module spongent_sbox4
    import spongent_sbox_stage_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] y
);

    assign y = SBOX_TBL[{a, 2'b00} +: 4];

endmodule

// File: rtl/spongent_sbox_stage.sv
// Byte-serial sBoxLayer stage: adds lCounter (and its reversal) into the
// first/last byte of each round frame, substitutes both nibbles, and hands
// the byte plus its index to pLayer through a single registered stage.
module spongent_sbox_stage
    import spongent_sbox_stage_pkg::*;
#(
    parameter int              NSBOX   = NSBOX_DEF,
    parameter int              ROUNDS  = ROUNDS_DEF,
    parameter int              LC_W    = LC_W_DEF,
    parameter logic [LC_W-1:0] LC_INIT = LC_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [31:0] out_index,
    input  logic        out_ready,
    output logic        round_last,
    output logic        done
);

    localparam int IDX_W = (NSBOX  > 1) ? $clog2(NSBOX)  : 1;
    localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSBOX - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [LC_W-1:0] lfsr_step(input logic [LC_W-1:0] v);
        return {v[LC_W-2:0], v[LC_W-1] ^ v[LC_W-2]};
    endfunction

    logic [IDX_W-1:0] idx, cur_idx;
    logic [RND_W-1:0] round, cur_round;
    logic [LC_W-1:0]  lc, cur_lc;
    logic [7:0]       lc8, x;
    logic [3:0]       s_hi, s_lo;
    logic             accept, frame_end;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // start overrides the running counters for the byte accepted alongside it
    always_comb begin
        cur_idx   = start ? '0      : idx;
        cur_round = start ? '0      : round;
        cur_lc    = start ? LC_INIT : lc;
        lc8       = {{(8-LC_W){1'b0}}, cur_lc};
        x         = in_data;
        if (cur_idx == '0)      x = x ^ lc8;
        if (cur_idx == IDX_LAST) x = x ^ rev8(lc8);
        frame_end = (cur_idx == IDX_LAST);
    end

    spongent_sbox4 u_sbox_hi (.a(x[7:4]), .y(s_hi));
    spongent_sbox4 u_sbox_lo (.a(x[3:0]), .y(s_lo));

    // output register, byte index / round / lCounter bookkeeping, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            round_last <= 1'b0;
            done       <= 1'b0;
            idx        <= '0;
            round      <= '0;
            lc         <= LC_INIT;
        end else begin
            done <= out_valid && out_ready && round_last;
            if (accept) begin
                out_valid  <= 1'b1;
                out_data   <= {s_hi, s_lo};
                out_index  <= {{(32-IDX_W){1'b0}}, cur_idx};
                round_last <= frame_end && (cur_round == RND_LAST);
                if (frame_end) begin
                    idx <= '0;
                    if (cur_round == RND_LAST) begin
                        round <= '0;
                        lc    <= LC_INIT;
                    end else begin
                        round <= cur_round + 1'b1;
                        lc    <= lfsr_step(cur_lc);
                    end
                end else begin
                    idx   <= cur_idx + 1'b1;
                    round <= cur_round;
                    lc    <= cur_lc;
                end
            end else begin
                if (out_ready) begin
                    out_valid  <= 1'b0;
                    round_last <= 1'b0;
                end
                if (start) begin
                    idx   <= '0;
                    round <= '0;
                    lc    <= LC_INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_spongent_sbox_stage.sv
// Scoreboard bench for spongent_sbox_stage (Spongent-88 and an NSBOX=1 copy).
module tb_spongent_sbox_stage;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] index;
        logic        rl;
    } exp_t;

    logic        clk = 0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, round_last, done;
    logic [7:0]  out_data;
    logic [31:0] out_index;

    logic        start1, in_valid1;
    logic [7:0]  in_data1;
    logic        in_ready1, out_valid1, round_last1, done1;
    logic [7:0]  out_data1;
    logic [31:0] out_index1;

    int   checks = 0, errors = 0, done_cnt = 0;
    bit   done_pend = 0;
    exp_t sb[$];

    int         m_idx, m_round;
    logic [5:0] m_lc;

    always #5 clk = ~clk;

    spongent_sbox_stage dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_index(out_index), .out_ready(out_ready), .round_last(round_last), .done(done));

    spongent_sbox_stage #(.NSBOX(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_index(out_index1), .out_ready(1'b1), .round_last(round_last1), .done(done1));

    function automatic logic [3:0] s4(input logic [3:0] a);
        logic [3:0] t [16];
        t = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
              4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
        return t[a];
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] d, input int i, input logic [5:0] lc);
        logic [7:0] l, r, xx;
        l = {2'b00, lc};
        for (int k = 0; k < 8; k++) r[k] = l[7-k];
        xx = d;
        if (i == 0)  xx = xx ^ l;
        if (i == 10) xx = xx ^ r;
        return {s4(xx[7:4]), s4(xx[3:0])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one byte; push the expected response once its acceptance is certain.
    task automatic send(input logic [7:0] d, input bit use_hand, input logic [7:0] hand,
                        input bit rnd_ready, input bit with_start);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; start = with_start;
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end else begin
            if (with_start) begin m_idx = 0; m_round = 0; m_lc = 6'h05; end
            e.data  = use_hand ? hand : model_byte(d, m_idx, m_lc);
            e.index = m_idx;
            e.rl    = (m_idx == 10) && (m_round == 44);
            sb.push_back(e);
            if (m_idx == 10) begin
                m_idx = 0;
                if (m_round == 44) begin m_round = 0; m_lc = 6'h05; end
                else begin m_round++; m_lc = {m_lc[4:0], m_lc[5] ^ m_lc[4]}; end
            end else m_idx++;
        end
        @(posedge clk); #1;
        start = 0; in_valid = 0;
    endtask

    task automatic send_zero_frame(input logic [7:0] b0, input logic [7:0] bm,
                                   input logic [7:0] b10, input bit first_start);
        for (int i = 0; i < 11; i++)
            send(8'h00, 1'b1, (i == 0) ? b0 : (i == 10) ? b10 : bm, 1'b0, first_start && i == 0);
    endtask

    // Monitor: pop and compare on every output handshake; track done pulses.
    always begin
        @(negedge clk); #2;
        if (done_pend) begin
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b required 1", done); end
        end else if (done === 1'b1) begin
            checks++; errors++;
            $display("FAIL done_spurious: got 1 required 0");
        end
        done_pend = 0;
        if (done === 1'b1) done_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_extra: unexpected byte %0h idx %0d", out_data, out_index);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data",   out_data,   e.data);
                chk("out_index",  out_index,  e.index);
                chk("round_last", round_last, e.rl);
                if (e.rl) done_pend = 1;
            end
        end
    end

    initial begin
        logic [7:0] held;
        rst = 1; start = 0; in_valid = 0; in_data = 0; out_ready = 1;
        start1 = 0; in_valid1 = 0; in_data1 = 0;
        m_idx = 0; m_round = 0; m_lc = 6'h05;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_data",   out_data,   0);
        chk("rst_out_index",  out_index,  0);
        chk("rst_round_last", round_last, 0);
        chk("rst_done",       done,       0);
        chk("rst_in_ready",   in_ready,   1);
        @(negedge clk); rst = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;

        // frames 0 and 1, all-zero, hand-computed
        send_zero_frame(8'hE1, 8'hEE, 8'h8E, 1'b0);
        send_zero_frame(8'hE8, 8'hEE, 8'h1E, 1'b0);

        // frame 2: backpressure after byte 0
        send(8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        held = model_byte(8'h3C, 0, 6'h14);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1; in_data = 8'h5A; out_ready = 0;
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_data", out_data, held);
            chk("bp_out_index", out_index, 0);
        end
        for (int i = 1; i < 11; i++)
            send((i == 1) ? 8'h5A : 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);

        // frames 3..44 with random data and random downstream stalls
        for (int f = 3; f < 45; f++)
            for (int i = 0; i < 11; i++)
                send(8'($urandom), 1'b0, 8'h00, 1'b1, 1'b0);

        // frame 45 byte 0: lCounter back at 0x05
        send(8'h00, 1'b1, 8'hE1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) send(8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
        chk("done_count", done_cnt, 1);

        // reset with idx=5 and byte 4 held in the output register
        @(negedge clk);
        out_ready = 0; rst = 1;
        #1;
        if (sb.size() > 0) void'(sb.pop_back());
        chk("midrst_out_valid",  out_valid,  0);
        chk("midrst_out_data",   out_data,   0);
        chk("midrst_out_index",  out_index,  0);
        chk("midrst_in_ready",   in_ready,   1);
        @(negedge clk); rst = 0; out_ready = 1;
        send_zero_frame(8'hE1, 8'hEE, 8'h8E, 1'b1);

        // NSBOX=1: both lCounter terms land on the single byte
        @(negedge clk); start1 = 1; in_valid1 = 1; in_data1 = 8'h00;
        @(posedge clk); #1; start1 = 0;
        chk("n1_r0_valid", out_valid1, 1);
        chk("n1_r0_data",  out_data1,  8'h81);
        chk("n1_r0_index", out_index1, 0);
        @(posedge clk); #1; in_valid1 = 0;
        chk("n1_r1_data",  out_data1,  8'h18);

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("done_total", done_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
